// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline: instruction codes, ALU and
// condition function codes, stat codes, the "no register" ID and the
// execute-to-memory bubble value, plus the ripple adder used by the ALU.
package y86_pkg;

  // Instruction codes (icode)
  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  // ALU functions (ifun of OPq); every 2-bit value is a legal member
  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluAnd = 2'd2,
    AluXor = 2'd3
  } alu_fn_e;

  // Condition functions (ifun of jXX / cmovXX)
  localparam logic [3:0] CondAlways = 4'h0;
  localparam logic [3:0] CondLe     = 4'h1;
  localparam logic [3:0] CondL      = 4'h2;
  localparam logic [3:0] CondE      = 4'h3;
  localparam logic [3:0] CondNe     = 4'h4;
  localparam logic [3:0] CondGe     = 4'h5;
  localparam logic [3:0] CondG      = 4'h6;

  // Stage status codes
  localparam logic [2:0] StatBub = 3'd0;
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  localparam logic [3:0] RegNone = 4'hF;

  // Condition codes are packed {ZF, SF, OF}; reset leaves only ZF set
  localparam logic [2:0] CcReset = 3'b100;

  // Execute-to-memory pipeline register contents
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } mreg_t;

  // Bubble value; the destination ID is passed in so a block can use its own RNONE
  function automatic mreg_t make_bubble(input logic [3:0] rnone);
    mreg_t b;
    b.stat  = StatBub;
    b.icode = IcodeNop;
    b.cnd   = 1'b0;
    b.val_e = '0;
    b.val_a = '0;
    b.dst_e = rnone;
    b.dst_m = rnone;
    return b;
  endfunction

  // 64-bit ripple-carry adder; subtraction is a + ~b with cin = 1
  function automatic logic [63:0] ripple_add(input logic [63:0] a, input logic [63:0] b,
                                             input logic cin);
    logic        c;
    logic [63:0] s;
    c = cin;
    for (int i = 0; i < 64; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Evaluates a jXX/cmovXX condition function against the condition codes
// {ZF, SF, OF}. Unknown function codes evaluate false.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       Cnd
);

  logic w_zf;
  logic w_lt;

  assign w_zf = cc[2];
  // Signed "less than" holds when the sign disagrees with the overflow flag
  assign w_lt = cc[1] ^ cc[0];

  // Decode the condition function
  always_comb begin
    Cnd = 1'b0;
    case (ifun)
      CondAlways: Cnd = 1'b1;
      CondLe:     Cnd = w_lt | w_zf;
      CondL:      Cnd = w_lt;
      CondE:      Cnd = w_zf;
      CondNe:     Cnd = ~w_zf;
      CondGe:     Cnd = ~w_lt;
      CondG:      Cnd = ~w_lt & ~w_zf;
      default:    Cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition codes,
// cmov destination squashing and the execute-to-memory pipeline register.
// Optional macro EXEC_CC_EXC_GATE_EN: when defined, a condition-code update
// is suppressed while the memory or writeback stage holds an exception.
// Only WIDTH = 64 is supported.
module execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             M_stall,
  input  logic             M_bubble,
  input  logic             m_exc,
  input  logic             W_exc,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc
);

  localparam mreg_t MBubble = make_bubble(RNONE);

  logic [63:0] w_alu_a;
  logic [63:0] w_alu_b;
  alu_fn_e     w_alu_fn;
  logic [63:0] w_sum;
  logic [63:0] w_diff;
  logic [63:0] w_alu_out;
  logic        w_of;
  logic [2:0]  w_cc_new;
  logic        w_cc_en;
  logic        w_cnd;
  mreg_t       w_m_next;
  logic [2:0]  r_cc;
  mreg_t       r_m;

  // Select the ALU A operand
  always_comb begin
    w_alu_a = '0;
    case (E_icode)
      IcodeOpq, IcodeRrmovq:                w_alu_a = E_valA;
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq: w_alu_a = E_valC;
      IcodeCall, IcodePushq:                w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      IcodeRet, IcodePopq:                  w_alu_a = 64'd8;
      default:                              w_alu_a = '0;
    endcase
  end

  // Select the ALU B operand
  always_comb begin
    w_alu_b = '0;
    case (E_icode)
      IcodeRmmovq, IcodeMrmovq, IcodeOpq, IcodeCall,
      IcodePushq, IcodeRet, IcodePopq:       w_alu_b = E_valB;
      default:                              w_alu_b = '0;
    endcase
  end

  // Only OPq chooses its own ALU function; everything else adds
  assign w_alu_fn = (E_icode == IcodeOpq && E_ifun[3:2] == 2'b00) ? alu_fn_e'(E_ifun[1:0])
                                                                  : AluAdd;

  assign w_sum  = ripple_add(w_alu_b, w_alu_a, 1'b0);
  assign w_diff = ripple_add(w_alu_b, ~w_alu_a, 1'b1);

  // ALU result and signed-overflow flag
  always_comb begin
    w_alu_out = w_sum;
    w_of      = 1'b0;
    case (w_alu_fn)
      AluAdd: begin
        w_alu_out = w_sum;
        w_of      = (w_alu_a[63] == w_alu_b[63]) && (w_sum[63] != w_alu_b[63]);
      end
      AluSub: begin
        w_alu_out = w_diff;
        w_of      = (w_alu_a[63] != w_alu_b[63]) && (w_diff[63] != w_alu_b[63]);
      end
      AluAnd:  w_alu_out = w_alu_b & w_alu_a;
      AluXor:  w_alu_out = w_alu_b ^ w_alu_a;
      default: w_alu_out = w_sum;
    endcase
  end

  assign w_cc_new = {(w_alu_out == 64'd0), w_alu_out[63], w_of};

`ifdef EXEC_CC_EXC_GATE_EN
  // A later-stage exception must not let this instruction change the flags
  assign w_cc_en = (E_icode == IcodeOpq) && !m_exc && !W_exc;
`else
  logic w_unused_exc;
  assign w_unused_exc = m_exc ^ W_exc;
  assign w_cc_en      = (E_icode == IcodeOpq);
`endif

  cond_eval u_cond_eval (
    .ifun (E_ifun),
    .cc   (r_cc),
    .Cnd  (w_cnd)
  );

  assign e_valE = w_alu_out;
  assign e_Cnd  = w_cnd;
  // A cmov whose condition fails writes nothing
  assign e_dstE = (E_icode == IcodeRrmovq && !w_cnd) ? RNONE : E_dstE;

  assign w_m_next = '{stat:  E_stat,
                      icode: E_icode,
                      cnd:   w_cnd,
                      val_e: w_alu_out,
                      val_a: E_valA,
                      dst_e: e_dstE,
                      dst_m: E_dstM};

  // Condition-code register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cc <= CcReset;
    end else if (w_cc_en) begin
      r_cc <= w_cc_new;
    end
  end

  // Execute-to-memory register; stall beats bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m <= MBubble;
    end else if (M_stall) begin
      r_m <= r_m;
    end else if (M_bubble) begin
      r_m <= MBubble;
    end else begin
      r_m <= w_m_next;
    end
  end

  assign cc      = r_cc;
  assign M_stat  = r_m.stat;
  assign M_icode = r_m.icode;
  assign M_Cnd   = r_m.cnd;
  assign M_valE  = r_m.val_e;
  assign M_valA  = r_m.val_a;
  assign M_dstE  = r_m.dst_e;
  assign M_dstM  = r_m.dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vectors followed by random
// instructions, compared against an instruction-level reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_stall, M_bubble, m_exc, W_exc;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic [2:0]  cc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        mdl_z, mdl_s, mdl_o;
  logic        mdl_cc_known = 1'b0;
  logic        mdl_m_known  = 1'b0;
  logic [2:0]  x_stat;
  logic [3:0]  x_icode, x_dstE, x_dstM;
  logic        x_cnd;
  logic [63:0] x_valE, x_valA;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_valC   (E_valC),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .M_stall  (M_stall),
    .M_bubble (M_bubble),
    .m_exc    (m_exc),
    .W_exc    (W_exc),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_Cnd    (e_Cnd),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM),
    .cc       (cc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What each instruction computes, stated per instruction
  function automatic logic [63:0] mdl_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c, output logic ovf);
    logic [64:0] wide;
    logic [63:0] r;
    r   = 64'd0;
    ovf = 1'b0;
    case (ic)
      4'h2: r = a;                         // rrmovq / cmovXX
      4'h3: r = c;                         // irmovq
      4'h4, 4'h5: r = b + c;               // address = base + displacement
      4'h6: begin
        case (fn)
          4'h0: begin
            wide = {b[63], b} + {a[63], a};
            r = wide[63:0];
            ovf = wide[64] != wide[63];
          end
          4'h1: begin
            wide = {b[63], b} - {a[63], a};
            r = wide[63:0];
            ovf = wide[64] != wide[63];
          end
          4'h2: r = a & b;
          default: r = a ^ b;
        endcase
      end
      4'h8, 4'hA: r = b - 64'd8;           // call / push grow the stack down
      4'h9, 4'hB: r = b + 64'd8;           // ret / pop
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic mdl_cond(input logic [3:0] fn, input logic z, input logic s,
                                    input logic o);
    logic less;
    less = s != o;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check registers
  task automatic step(input string tag);
    logic [63:0] ev;
    logic        ovf, cnd, gate;
    logic [3:0]  edst;
    ev   = mdl_vale(E_icode, E_ifun, E_valA, E_valB, E_valC, ovf);
    cnd  = mdl_cond(E_ifun, mdl_z, mdl_s, mdl_o);
    edst = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
    #1;
    check({tag, " e_valE"}, e_valE, ev);
    if (mdl_cc_known) begin
      check({tag, " e_Cnd"}, {63'd0, e_Cnd}, {63'd0, cnd});
      check({tag, " e_dstE"}, {60'd0, e_dstE}, {60'd0, edst});
    end
`ifdef EXEC_CC_EXC_GATE_EN
    gate = m_exc || W_exc;
`else
    gate = 1'b0;
`endif
    if (!rst_n) begin
      {mdl_z, mdl_s, mdl_o} = 3'b100;
      mdl_cc_known = 1'b1;
      {x_stat, x_icode, x_cnd, x_valE, x_valA, x_dstE, x_dstM} =
        {3'd0, 4'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
      mdl_m_known = 1'b1;
    end else begin
      if (!M_stall && M_bubble) begin
        {x_stat, x_icode, x_cnd, x_valE, x_valA, x_dstE, x_dstM} =
          {3'd0, 4'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
      end else if (!M_stall) begin
        {x_stat, x_icode, x_cnd, x_valE, x_valA, x_dstE, x_dstM} =
          {E_stat, E_icode, cnd, ev, E_valA, edst, E_dstM};
      end
      if (E_icode == 4'h6 && !gate) {mdl_z, mdl_s, mdl_o} = {ev == 64'd0, ev[63], ovf};
    end
    @(posedge clk);
    #1;
    if (mdl_cc_known) check({tag, " cc"}, {61'd0, cc}, {61'd0, mdl_z, mdl_s, mdl_o});
    if (mdl_m_known) begin
      check({tag, " M_stat"}, {61'd0, M_stat}, {61'd0, x_stat});
      check({tag, " M_icode"}, {60'd0, M_icode}, {60'd0, x_icode});
      check({tag, " M_Cnd"}, {63'd0, M_Cnd}, {63'd0, x_cnd});
      check({tag, " M_valE"}, M_valE, x_valE);
      check({tag, " M_valA"}, M_valA, x_valA);
      check({tag, " M_dstE"}, {60'd0, M_dstE}, {60'd0, x_dstE});
      check({tag, " M_dstM"}, {60'd0, M_dstM}, {60'd0, x_dstM});
    end
  endtask

  task automatic set_e(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                       input logic [63:0] vb, input logic [63:0] vc, input logic [3:0] de);
    E_stat  = 3'd1;
    E_icode = ic;
    E_ifun  = fn;
    E_valA  = va;
    E_valB  = vb;
    E_valC  = vc;
    E_dstE  = de;
    E_dstM  = 4'hF;
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'hFFFF_FFFF_FFFF_FFFF;
      default: v = v;
    endcase
    return v;
  endfunction

  initial begin
    mdl_z = 1'b0; mdl_s = 1'b0; mdl_o = 1'b0;
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; m_exc = 1'b0; W_exc = 1'b0;
    set_e(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);

    // Reset state
    step("reset0");
    step("reset1");
    check("reset cc", {61'd0, cc}, 64'd4);
    check("reset M_icode", {60'd0, M_icode}, 64'd1);
    rst_n = 1'b1;

    // SUB: 0x36 - 0x2E
    set_e(4'h6, 4'h1, 64'h2E, 64'h36, 64'd0, 4'h2);
    step("sub");
    check("sub e_valE", e_valE, 64'h8);
    check("sub cc", {61'd0, cc}, 64'd0);
    check("sub M_valE", M_valE, 64'h8);

    // ADD with signed overflow
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2);
    step("add_ovf");
    check("add_ovf e_valE", e_valE, 64'h8000_0000_0000_0000);
    check("add_ovf cc", {61'd0, cc}, 64'd3);

    // XOR to zero, then conditional moves against ZF=1
    set_e(4'h6, 4'h3, 64'h5, 64'h5, 64'd0, 4'h2);
    step("xor");
    check("xor cc", {61'd0, cc}, 64'd4);
    set_e(4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3);
    step("cmovle");
    check("cmovle e_Cnd", {63'd0, e_Cnd}, 64'd1);
    check("cmovle e_dstE", {60'd0, e_dstE}, 64'd3);
    set_e(4'h2, 4'h6, 64'h1234, 64'd0, 64'd0, 4'h3);
    step("cmovg");
    check("cmovg e_dstE", {60'd0, e_dstE}, 64'hF);

    // Stack adjustments leave the flags alone
    set_e(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4);
    step("push");
    check("push e_valE", e_valE, 64'hF8);
    check("push cc", {61'd0, cc}, 64'd4);
    set_e(4'hB, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4);
    step("pop");
    check("pop e_valE", e_valE, 64'h108);

    // Stall twice with changing inputs, then bubble, then stall+bubble
    M_stall = 1'b1;
    set_e(4'h3, 4'h0, 64'd0, 64'd0, 64'hABC, 4'h5);
    step("stall0");
    set_e(4'h5, 4'h0, 64'd0, 64'h40, 64'h8, 4'h6);
    step("stall1");
    check("stall M_valE", M_valE, 64'h108);
    M_bubble = 1'b1;
    step("stall_bubble");
    M_stall = 1'b0;
    step("bubble");
    check("bubble M_icode", {60'd0, M_icode}, 64'd1);
    check("bubble M_dstE", {60'd0, M_dstE}, 64'hF);
    M_bubble = 1'b0;

    // SUB while writeback holds an exception
    W_exc = 1'b1;
    set_e(4'h6, 4'h1, 64'd1, 64'd3, 64'd0, 4'h1);
    step("sub_wexc");
    W_exc = 1'b0;

    // Reset arriving mid-stream wins over the flag update and a stall
    set_e(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'h1);
    rst_n = 1'b0;
    M_stall = 1'b1;
    step("midreset");
    check("midreset cc", {61'd0, cc}, 64'd4);
    check("midreset M_stat", {61'd0, M_stat}, 64'd0);
    rst_n = 1'b1;
    M_stall = 1'b0;

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      E_stat   = 3'($urandom_range(0, 4));
      E_icode  = 4'($urandom_range(0, 11));
      E_ifun   = (E_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      E_valA   = rand_val();
      E_valB   = rand_val();
      E_valC   = rand_val();
      E_dstE   = 4'($urandom_range(0, 15));
      E_dstM   = 4'($urandom_range(0, 15));
      M_stall  = ($urandom_range(0, 7) == 0);
      M_bubble = ($urandom_range(0, 7) == 0);
      m_exc    = ($urandom_range(0, 3) == 0);
      W_exc    = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 31) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
